rx_frame_controller: RTL

Receive-side frame sequencer for the serial link: hunts for a sync word on the raw bit stream, parses an 8-bit length header and gates the byte deserializer for exactly the payload bits. It forwards each deserialized payload byte and, optionally, verifies a trailing checksum. It sits between the line receiver and the byte deserializer and supplies the downstream demodulation/packet logic with framed bytes.

---
 rtl/rx_frame_controller.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_controller.sv
// rx_frame_controller
//
// Receive-side frame sequencer. Hunts the raw line for SYNC_WORD, parses an
// 8-bit length header, gates the byte deserializer for exactly the payload
// bits and forwards each deserialized byte. When the RX_CHECKSUM_EN macro is
// defined, a trailing 8-bit mod-256 sum of the payload is read from the line
// and verified.
//
// Parameters:
//   SYNC_WORD  sync pattern, MSB first on the line
//   MAX_LEN    largest legal payload length in bytes (1..255)
//   TIMEOUT    max cycles in PAYLOAD between consecutive deser_valid pulses
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   enable       level; low forces IDLE
//   serial_in    line bit, MSB first
//   deser_data   byte from the deserializer
//   deser_valid  deserializer byte strobe (asserted with the byte's 8th bit)
//   deser_start  enables/holds the deserializer; low clears it
//   byte_out     forwarded payload byte
//   byte_valid   1-cycle strobe with byte_out
//   frame_start  1-cycle pulse on sync detect
//   frame_done   1-cycle pulse on good frame end
//   frame_err    1-cycle pulse on frame abort
//   frame_len    length header of the current/last frame
//   busy         high in LEN, PAYLOAD and CHECK
module rx_frame_controller #(
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       serial_in,
  input  logic [7:0] deser_data,
  input  logic       deser_valid,
  output logic       deser_start,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] frame_len,
  output logic       busy
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

`ifdef RX_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StHunt, StLen, StPayload, StCheck} state_t;
`else
  typedef enum logic [2:0] {StIdle, StHunt, StLen, StPayload} state_t;
`endif

  state_t        state_q;
  logic [7:0]    hunt_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    byte_cnt_q;
  logic [TW-1:0] tmo_q;
`ifdef RX_CHECKSUM_EN
  logic [7:0]    sum_q;
`endif

  logic [7:0] hunt_next;
  logic [7:0] shift_next;
  logic [7:0] byte_cnt_next;

  assign hunt_next     = {hunt_q[6:0], serial_in};
  assign shift_next    = {shift_q[6:0], serial_in};
  assign byte_cnt_next = byte_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      hunt_q      <= 8'h00;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 8'h00;
      tmo_q       <= '0;
`ifdef RX_CHECKSUM_EN
      sum_q       <= 8'h00;
`endif
      deser_start <= 1'b0;
      byte_out    <= 8'h00;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_len   <= 8'h00;
      busy        <= 1'b0;
    end else begin
      // Strobes default low; each is raised only in its deciding cycle.
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      byte_valid  <= 1'b0;
      if (!enable) begin
        // Silent abort: partial frame dropped, no done/err pulse.
        state_q     <= StIdle;
        deser_start <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q <= StHunt;
            hunt_q  <= 8'h00;
          end
          StHunt: begin
            hunt_q <= hunt_next;
            if (hunt_next == SYNC_WORD) begin
              state_q     <= StLen;
              frame_start <= 1'b1;
              bit_cnt_q   <= 3'd0;
              busy        <= 1'b1;
            end
          end
          StLen: begin
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_next == 8'h00 || {24'd0, shift_next} > MAX_LEN) begin
                frame_err <= 1'b1;
                busy      <= 1'b0;
                hunt_q    <= 8'h00;
                state_q   <= StHunt;
              end else begin
                frame_len   <= shift_next;
                byte_cnt_q  <= 8'h00;
`ifdef RX_CHECKSUM_EN
                sum_q       <= 8'h00;
`endif
                tmo_q       <= '0;
                deser_start <= 1'b1;
                state_q     <= StPayload;
              end
            end
          end
          StPayload: begin
            if (deser_valid) begin
              byte_out   <= deser_data;
              byte_valid <= 1'b1;
              byte_cnt_q <= byte_cnt_next;
              tmo_q      <= '0;
`ifdef RX_CHECKSUM_EN
              sum_q      <= sum_q + deser_data;
`endif
              if (byte_cnt_next == frame_len) begin
                deser_start <= 1'b0;
`ifdef RX_CHECKSUM_EN
                bit_cnt_q   <= 3'd0;
                state_q     <= StCheck;
`else
                frame_done  <= 1'b1;
                busy        <= 1'b0;
                hunt_q      <= 8'h00;
                state_q     <= StHunt;
`endif
              end
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
              frame_err   <= 1'b1;
              deser_start <= 1'b0;
              busy        <= 1'b0;
              hunt_q      <= 8'h00;
              state_q     <= StHunt;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
`ifdef RX_CHECKSUM_EN
          StCheck: begin
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_next == sum_q) begin
                frame_done <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              busy    <= 1'b0;
              hunt_q  <= 8'h00;
              state_q <= StHunt;
            end
          end
`endif
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
